// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done request bundle between a requester (master) and the serial adder (slave).
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; zero latency, no flow control.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first through one fa_cell; done pulses WIDTH+1 edges after start.
// start is accepted only in IDLE and never queued; SERIAL_ADDER_SUB_EN adds a-b via sub.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sub_in;
  logic             fa_s, fa_c;
  logic             busy, done;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  fa_cell u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      pr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      pr_q    <= pr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: subtraction is a + ~b + 1, so sub forces the carry-in high.
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    pr_d    = pr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && bus.start) begin
      sa_d    = bus.a;
      sb_d    = sub_in ? ~bus.b : bus.b;
      carry_d = sub_in | bus.cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      sa_d    = sa_q >> 1;
      sb_d    = sb_q >> 1;
      pr_d    = {fa_s, {(WIDTH-1){1'b0}}} | (pr_q >> 1);
      carry_d = fa_c;
      if (last_bit) begin
        sum_d  = pr_d;
        cout_d = fa_c;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts);
    bus.start = st;
    bus.a     = ta;
    bus.b     = tb_;
    bus.cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = ts;
`else
    if (ts) $display("note: sub requested in add-only build");
`endif
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts);
    int unsigned r;
    if (ts) begin
      r        = (int'(ta) - int'(tb_) + 256) % 256;
      exp_sum  = W'(r);
      exp_cout = (ta >= tb_);
    end else begin
      r        = int'(ta) + int'(tb_) + int'(tc);
      exp_sum  = W'(r % 256);
      exp_cout = (r >= 256);
    end
  endtask

  // One operation from a negedge; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts, input bit mid);
    int   done_at;
    int   n_done;
    int   n_busy;
    bit   stable;
    logic [W-1:0] old_sum;
    logic         old_cout;
    old_sum  = exp_sum;
    old_cout = exp_cout;
    done_at  = -1;
    n_done   = 0;
    n_busy   = 0;
    stable   = 1'b1;
    drive(1'b1, ta, tb_, tc, ts);
    @(negedge clk);
    drive(1'b0, ~ta, ~tb_, ~tc, 1'b0);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_after_start", 32'(bus.done), 32'd0);
    for (int i = 1; i <= W + 2; i++) begin
      if (mid && i == 2) drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
      if (mid && i == 3) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        done_at = i;
      end
      if (bus.busy === 1'b1) n_busy++;
      if (i < W && (bus.sum !== old_sum || bus.cout !== old_cout)) stable = 1'b0;
    end
    model(ta, tb_, tc, ts);
    check("done_latency", 32'(done_at), 32'(W));
    check("done_count", 32'(n_done), 32'd1);
    check("busy_cycles", 32'(n_busy + 1), 32'(W + 1));
    check("sum_stable", 32'(stable), 32'd1);
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("cout", 32'(bus.cout), 32'(exp_cout));
    check("idle_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d_at[$];
    bit saw_done;
    n_checks = 0;
    n_fail   = 0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    rst_n    = 1'b0;
    drive(1'b1, 8'h3C, 8'h0F, 1'b1, 1'b0);

    // Reset with start held high must not begin an operation.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(bus.busy), 32'd0);

    run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);

    // Held start: second acceptance at the first IDLE edge.
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    for (int j = 0; j <= 2 * W + 3; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) d_at.push_back(j);
      if (j == W + 1) check("held_gap_idle", 32'(bus.busy), 32'd0);
      if (j == W + 2) check("held_reaccept", 32'(bus.busy), 32'd1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (W + 3) @(negedge clk);
    model(8'h12, 8'h34, 1'b0, 1'b0);
    check("held_done_count", 32'(d_at.size()), 32'd2);
    if (d_at.size() == 2) begin
      check("held_done0", 32'(d_at[0]), 32'(W));
      check("held_done1", 32'(d_at[1]), 32'(2 * W + 2));
    end
    check("held_sum", 32'(bus.sum), 32'(exp_sum));

    // Reset at the fourth RUN edge abandons the operation.
    drive(1'b1, 8'h40, 8'h41, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    saw_done = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    run_op(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
    run_op(8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
`endif

    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
